unar_pattern_tx: RTL and testbench
==================================

// Module: unar_pattern_tx
// PURPOSE
// - Serial pattern transmitter: drives a single-bit line with a fixed PAT_W-bit pattern
//   (default 1100), MSB first, one bit per bit-rate tick, repeated 'reps' times.
// - Transmit-side counterpart of the 1100 sequence detector; feeds detector x input on board tests.
// - Exposes FSM state as a 7-segment literal for the board display.
// PARAMETERS
// - PAT_W     4        pattern length in bits
// - PATTERN   4'b1100  pattern bits, sent MSB first
// - CNT_W     4        width of repetition count
// - GAP_BITS  0        idle (0) bit periods between repetitions; 0 = back-to-back
// PORTS
// - Clock       in   1      system clock, rising edge
// - Reset       in   1      asynchronous, active-low reset
// - tick        in   1      bit-rate enable, 1-clock pulse per bit period
// - start       in   1      request transmission; sampled only in IDLE
// - reps        in   CNT_W  number of pattern repetitions; latched on accepted start
// - x_out       out  1      serial line, registered
// - busy        out  1      high in SHIFT and GAP
// - done        out  1      1-clock pulse at end of transmission
// - chk_err     out  1      loopback mismatch flag (see CONFIGURATION)
// - st_literal  out  8      active-low 7-seg code of current state
// BEHAVIOUR
// - Reset (Reset=0, async): state IDLE, x_out=0, busy=0, done=0, chk_err=0, counters 0,
//   st_literal=8'b1100_0000. Reset mid-transmission aborts immediately; no done pulse.
// - One-hot FSM, states IDLE, SHIFT, GAP, DONE.
// - IDLE: start=1 and reps!=0 -> latch reps, load shift reg with PATTERN, bit_cnt=PAT_W,
//   next SHIFT. start=1 and reps==0 -> next DONE, no bits sent. start while busy: ignored.
// - SHIFT: on tick: x_out<=sr[PAT_W-1], sr<<=1, bit_cnt--. On the tick following the
//   last bit of a rep: if reps remain -> reload PATTERN, and go GAP if GAP_BITS>0, else
//   emit first bit of next rep on that same tick (no idle bit inserted).
//   If last rep -> x_out<=0, next DONE.
// - GAP: x_out=0 for GAP_BITS ticks, then on the next tick emit first bit of next rep, SHIFT.
// - DONE: done=1 for exactly one clock, then IDLE. start in DONE is ignored.
// - Clocks without tick: x_out, counters and shift reg hold.
// - Latency: first bit appears on x_out at the first tick after start is accepted.
// - Each bit holds for exactly one tick period.
// - tick coincident with start in IDLE does not emit a bit.
// - rep counter decrements at end of each rep. No wrap: full-scale reps (all 1s) sends 2^CNT_W-1 reps.
// - st_literal, decoded from state:
//   - IDLE  = 8'b1100_0000
//   - SHIFT = 8'b1001_0010
//   - GAP   = 8'b1000_1100
//   - DONE  = 8'b1010_0001
// CONFIGURATION
// - Macro UNAR_TX_LOOPBACK_CHECK_EN.
// - Defined: instantiate 1100 Mealy detector on x_out, clocked only when tick=1.
//   - Count its detections during a transmission.
//   - In DONE, chk_err<=1 if count != latched reps (PATTERN=1100 only).
//   - chk_err is sticky until Reset or next accepted start.
// - Undefined: no detector logic; chk_err tied 0.
// STRUCTURE
// - Package unar_pkg:
//   - state bit indices (IDLE_BIT..DONE_BIT)
//   - one-hot enum tx_state_t
//   - 7-seg literal constants (SEG_IDLE, SEG_SHIFT, SEG_GAP, SEG_DONE)
// - Sub-module unar_seq_det: tick-enabled 1100 detector, present only under the macro.
// - Top: FSM, shift register, bit_cnt, rep_cnt, gap_cnt.
// TESTING (PATTERN=1100, GAP_BITS=0, tick every 4 clocks unless noted)
// - Idle: after Reset release, no start for 20 clocks -> x_out=0, busy=0, done=0, st_literal=8'hC0.
// - reps=2 -> x_out per tick 1,1,0,0,1,1,0,0, then 0.
//   busy high throughout; one done pulse; chk_err=0 with macro.
// - GAP_BITS=2, reps=2 -> 1,1,0,0,0,0,1,1,0,0, then 0; st_literal=8'h8C during gap ticks.
// - reps=0 with start -> DONE next clock, done pulse, x_out stays 0, busy never high.
// - Reset=0 during 2nd bit of reps=3 -> x_out=0 and IDLE immediately, no done.
//   New start after release transmits normally.
// - start pulsed while busy (reps=1 running) -> ignored; exactly 4 bits sent, one done pulse.

Source files
------------

// File: rtl/unar_pkg.sv
// Shared definitions for the unar pattern transmitter: one-hot state
// encoding, 7-segment state literals and the state-to-literal decode.
package unar_pkg;

  // Bit positions of each state inside the one-hot state vector.
  localparam int IDLE_BIT  = 0;
  localparam int SHIFT_BIT = 1;
  localparam int GAP_BIT   = 2;
  localparam int DONE_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_GAP   = 4'b0100,
    ST_DONE  = 4'b1000
  } tx_state_t;

  // Active-low 7-segment codes shown on the board display for each state.
  localparam logic [7:0] SEG_IDLE  = 8'b1100_0000;
  localparam logic [7:0] SEG_SHIFT = 8'b1001_0010;
  localparam logic [7:0] SEG_GAP   = 8'b1000_1100;
  localparam logic [7:0] SEG_DONE  = 8'b1010_0001;

  function automatic logic [7:0] state_to_seg(input tx_state_t s);
    logic [7:0] seg;
    seg = SEG_IDLE;
    if (s[SHIFT_BIT]) seg = SEG_SHIFT;
    if (s[GAP_BIT])   seg = SEG_GAP;
    if (s[DONE_BIT])  seg = SEG_DONE;
    return seg;
  endfunction

endpackage

// File: rtl/unar_seq_det.sv
// Tick-enabled Mealy detector for the overlapping sequence 1100.
// Used only when UNAR_TX_LOOPBACK_CHECK_EN is defined, to watch x_out.
module unar_seq_det (
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  input  logic x,
  output logic det
);

  typedef enum logic [1:0] {D_S0, D_S1, D_S11, D_S110} det_state_t;

  det_state_t state, state_nx;

  // State register advances only on bit-rate ticks.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)  state <= D_S0;
    else if (en) state <= state_nx;
  end

  // Next-state and Mealy detect output for the 1100 sequence.
  always_comb begin
    state_nx = state;
    det      = 1'b0;
    case (state)
      D_S0:   state_nx = x ? D_S1  : D_S0;
      D_S1:   state_nx = x ? D_S11 : D_S0;
      D_S11:  state_nx = x ? D_S11 : D_S110;
      D_S110: begin
        state_nx = x ? D_S1 : D_S0;
        det      = en & ~x;
      end
      default: state_nx = D_S0;
    endcase
  end

endmodule

// File: rtl/unar_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB first on x_out, one
// bit per tick, 'reps' times, with optional idle gaps between repetitions.
// Optional loopback self-check enabled by macro UNAR_TX_LOOPBACK_CHECK_EN.
module unar_pattern_tx
  import unar_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1100,
  parameter int               CNT_W    = 4,
  parameter int               GAP_BITS = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic             chk_err,
  output logic [7:0]       st_literal
);

  localparam int BC_W  = $clog2(PAT_W + 1);
  // gap_cnt only has to hold GAP_BITS-1: the first gap bit is emitted on
  // the tick that leaves SHIFT.
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  tx_state_t        state, state_nx;
  logic [PAT_W-1:0] sr;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic accept, accept_zero, rep_end, last_rep, gap_end;

  assign accept      = state[IDLE_BIT] & start & (reps != '0);
  assign accept_zero = state[IDLE_BIT] & start & (reps == '0);
  assign rep_end     = state[SHIFT_BIT] & tick & (bit_cnt == '0);
  assign last_rep    = (rep_cnt == CNT_W'(1));
  assign gap_end     = state[GAP_BIT] & tick & (gap_cnt == '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_nx   = state;
    busy       = state[SHIFT_BIT] | state[GAP_BIT];
    done       = state[DONE_BIT];
    st_literal = state_to_seg(state);
    case (state)
      ST_IDLE: begin
        if (accept)           state_nx = ST_SHIFT;
        else if (accept_zero) state_nx = ST_DONE;
      end
      ST_SHIFT: begin
        if (rep_end) begin
          if (last_rep)          state_nx = ST_DONE;
          else if (GAP_BITS > 0) state_nx = ST_GAP;
        end
      end
      ST_GAP:  if (gap_end) state_nx = ST_SHIFT;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift register, line driver and bit/rep/gap counters; all hold without tick.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      x_out   <= 1'b0;
      sr      <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr      <= PATTERN;
            bit_cnt <= BC_W'(PAT_W);
            rep_cnt <= reps;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bit_cnt != '0) begin
              x_out   <= sr[PAT_W-1];
              sr      <= sr << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              rep_cnt <= rep_cnt - 1'b1;
              if (last_rep) begin
                x_out <= 1'b0;
              end else if (GAP_BITS > 0) begin
                x_out   <= 1'b0;
                sr      <= PATTERN;
                bit_cnt <= BC_W'(PAT_W);
                gap_cnt <= GAP_W'(GAP_BITS - 1);
              end else begin
                // Back-to-back: first bit of the next rep goes out on this tick.
                x_out   <= PATTERN[PAT_W-1];
                sr      <= PATTERN << 1;
                bit_cnt <= BC_W'(PAT_W - 1);
              end
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else begin
              x_out   <= sr[PAT_W-1];
              sr      <= sr << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UNAR_TX_LOOPBACK_CHECK_EN
  logic             det;
  logic [CNT_W-1:0] det_cnt;
  logic [CNT_W-1:0] reps_lat;
  logic             chk_q;

  unar_seq_det u_det (
    .Clock (Clock),
    .Reset (Reset),
    .en    (tick),
    .x     (x_out),
    .det   (det)
  );

  // Count detections while transmitting; compare against reps in DONE.
  // Meaningful only for PATTERN = 1100, which the detector recognises.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      det_cnt  <= '0;
      reps_lat <= '0;
      chk_q    <= 1'b0;
    end else begin
      if (accept || accept_zero) begin
        det_cnt  <= '0;
        reps_lat <= reps;
        chk_q    <= 1'b0;
      end else if (busy && det) begin
        det_cnt <= det_cnt + 1'b1;
      end
      if (state[DONE_BIT] && (det_cnt != reps_lat)) chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_unar_pattern_tx.sv
// Self-checking bench for unar_pattern_tx: one instance back-to-back
// (GAP_BITS=0) and one with GAP_BITS=2, tick every 4 clocks.
module tb_unar_pattern_tx;
  import unar_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       tick = 1'b0;
  logic       tick_fired = 1'b0;
  logic       start0 = 1'b0, startg = 1'b0;
  logic [3:0] reps0 = '0, repsg = '0;

  logic       x0, busy0, done0, err0;
  logic [7:0] seg0;
  logic       xg, busyg, doneg, errg;
  logic [7:0] segg;

  int sel = 0;
  logic       obs_x, obs_busy, obs_done, obs_err;
  logic [7:0] obs_seg;

  assign obs_x    = (sel == 1) ? xg    : x0;
  assign obs_busy = (sel == 1) ? busyg : busy0;
  assign obs_done = (sel == 1) ? doneg : done0;
  assign obs_err  = (sel == 1) ? errg  : err0;
  assign obs_seg  = (sel == 1) ? segg  : seg0;

  always #5 Clock = ~Clock;

  unar_pattern_tx #(.GAP_BITS(0)) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .start(start0), .reps(reps0),
    .x_out(x0), .busy(busy0), .done(done0), .chk_err(err0), .st_literal(seg0)
  );

  unar_pattern_tx #(.GAP_BITS(2)) dut_g (
    .Clock(Clock), .Reset(Reset), .tick(tick), .start(startg), .reps(repsg),
    .x_out(xg), .busy(busyg), .done(doneg), .chk_err(errg), .st_literal(segg)
  );

  // Scoreboard entry: expected line value and which state should be showing.
  typedef struct packed {
    logic       val;
    logic [1:0] kind;  // 0 = pattern bit, 1 = gap bit, 2 = final idle bit
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // tick: one clock high out of every four; tick_fired records the value
  // sampled by the design at the most recent rising edge.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge Clock);
      tick_fired = tick;
      #1;
      n = (n + 1) % 4;
      tick = (n == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic push_model(input int r, input int gap);
    logic [3:0] pat;
    exp_t e;
    pat = 4'b1100;
    for (int i = 0; i < r; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          e.val = 1'b0; e.kind = 2'd1; q.push_back(e);
        end
      end
      for (int b = 3; b >= 0; b--) begin
        e.val = pat[b]; e.kind = 2'd0; q.push_back(e);
      end
    end
    e.val = 1'b0; e.kind = 2'd2; q.push_back(e);
  endtask

  // Run one transmission on instance s; optionally pulse start again after
  // 'poke' bits have been observed (must be ignored).
  task automatic send(input int s, input int r, input int gap, input int poke);
    int pops, dones, busy_low, busy_tail, guard;
    exp_t e;
    sel = s;
    push_model(r, gap);
    if (s == 1) begin startg = 1'b1; repsg = 4'(r); end
    else        begin start0 = 1'b1; reps0 = 4'(r); end
    cyc();
    pops = 0; dones = 0; busy_low = 0; busy_tail = 0; guard = 0;
    if (!obs_busy) busy_low++;
    while (q.size() > 0 && guard < 2000) begin
      start0 = 1'b0; startg = 1'b0;
      cyc();
      guard++;
      if (obs_done) dones++;
      if (tick_fired) begin
        e = q.pop_front();
        pops++;
        check($sformatf("x_out bit%0d", pops), obs_x, e.val);
        case (e.kind)
          2'd0: check($sformatf("seg shift bit%0d", pops), obs_seg, SEG_SHIFT);
          2'd1: check($sformatf("seg gap bit%0d", pops), obs_seg, SEG_GAP);
          default: begin
            check("seg done", obs_seg, SEG_DONE);
            check("done at end", obs_done, 1);
          end
        endcase
        if (pops == poke) begin
          if (s == 1) begin startg = 1'b1; repsg = 4'd5; end
          else        begin start0 = 1'b1; reps0 = 4'd5; end
        end
      end
      if (q.size() > 0 && !obs_busy) busy_low++;
    end
    start0 = 1'b0; startg = 1'b0;
    check("all bits sent", q.size(), 0);
    q.delete();
    repeat (24) begin
      cyc();
      if (obs_done) dones++;
      if (obs_busy) busy_tail++;
      if (tick_fired) check("x_out idle after", obs_x, 0);
    end
    check("busy gaps", busy_low, 0);
    check("busy after", busy_tail, 0);
    check("done pulses", dones, 1);
    check("seg idle after", obs_seg, SEG_IDLE);
    check("chk_err", obs_err, 0);
  endtask

  initial begin
    int pops, dones, busy_hi, x_hi, guard;

    // Reset state while held in reset.
    repeat (3) cyc();
    check("rst x_out", x0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst chk_err", err0, 0);
    check("rst seg", seg0, SEG_IDLE);
    check("rst seg gapdut", segg, SEG_IDLE);

    // Idle for 20 clocks after release.
    Reset = 1'b1;
    busy_hi = 0; dones = 0; x_hi = 0;
    repeat (20) begin
      cyc();
      if (busy0) busy_hi++;
      if (done0) dones++;
      if (x0) x_hi++;
    end
    check("idle busy", busy_hi, 0);
    check("idle done", dones, 0);
    check("idle x_out", x_hi, 0);
    check("idle seg", seg0, 8'hC0);

    // reps=2, back-to-back, start coincident with a tick.
    guard = 0;
    while (tick !== 1'b1 && guard < 8) begin cyc(); guard++; end
    send(0, 2, 0, 0);

    // reps=2 with two gap bits between repetitions.
    send(1, 2, 2, 0);

    // reps=0: straight to DONE, nothing sent.
    sel = 0;
    start0 = 1'b1; reps0 = 4'd0;
    cyc();
    start0 = 1'b0;
    check("reps0 done", done0, 1);
    check("reps0 seg", seg0, SEG_DONE);
    check("reps0 busy", busy0, 0);
    busy_hi = 0; dones = 0; x_hi = 0;
    repeat (16) begin
      cyc();
      if (busy0) busy_hi++;
      if (done0) dones++;
      if (x0) x_hi++;
    end
    check("reps0 busy later", busy_hi, 0);
    check("reps0 extra done", dones, 0);
    check("reps0 x_out", x_hi, 0);
    check("reps0 chk_err", err0, 0);
    check("reps0 seg idle", seg0, SEG_IDLE);

    // Reset during the 2nd bit of reps=3.
    start0 = 1'b1; reps0 = 4'd3;
    cyc();
    start0 = 1'b0;
    pops = 0; guard = 0;
    while (pops < 2 && guard < 100) begin
      cyc();
      guard++;
      if (tick_fired) pops++;
    end
    check("abort reached bit2", pops, 2);
    check("abort bit2 value", x0, 1);
    #1 Reset = 1'b0;
    #1;
    check("abort x_out", x0, 0);
    check("abort seg", seg0, SEG_IDLE);
    check("abort busy", busy0, 0);
    check("abort done", done0, 0);
    dones = 0;
    repeat (8) begin
      cyc();
      if (done0) dones++;
    end
    check("abort no done", dones, 0);
    Reset = 1'b1;
    repeat (3) cyc();

    // Normal transmission after reset release.
    send(0, 1, 0, 0);

    // start pulsed while busy with reps=1: ignored.
    send(0, 1, 0, 2);

    // Full-scale reps: 15 repetitions, no wrap.
    send(0, 15, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
